serial_subtractor: RTL and testbench

Bit-serial unsigned/two's-complement subtractor computing `diff = a - b` over `WIDTH` cycles. It uses one `full_adder` cell with an inverted `b` operand and a carry-in of 1. This is the subtraction counterpart of the combinational adder path, intended for area-minimal ALU experiments. It exposes a start/busy/done handshake and Hack-style `zr`/`ng` flags.

---
 rtl/serial_subtractor_pkg.sv | 8 +
 rtl/serial_subtractor_full_adder.sv | 11 +
 rtl/serial_subtractor.sv | 79 +++++++
 tb/tb_serial_subtractor.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encoding shared by the serial subtractor
package serial_subtractor_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor_full_adder.sv
// full_adder: single-bit cell, the only arithmetic in the subtractor datapath
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b using one full adder, ~b and carry-in 1
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zr,
  output logic             ng
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_opa, r_opb, r_diff;
  logic [WIDTH-2:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_busy, r_done, r_borrow, r_zr, r_ng;
  logic             w_sum, w_cout;
  logic [WIDTH-1:0] w_res;
  full_adder u_fa (.a(r_opa[0]), .b(r_opb[0]), .cin(r_carry), .sum(w_sum), .cout(w_cout));
  // Completed result once the current sum bit lands in the MSB
  assign w_res = {w_sum, r_res};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zr     <= 1'b1;
      r_ng     <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_res   <= w_res[WIDTH-1:1];
      r_carry <= w_cout;
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_state  <= DONE;
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_diff   <= w_res;
        r_borrow <= ~w_cout;
        r_zr     <= ~|w_res;
        r_ng     <= w_sum;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (start) begin
      r_state <= SHIFT;
      r_opa   <= a;
      r_opb   <= ~b;
      r_carry <= 1'b1;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end
  end
  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign zr     = r_zr;
  assign ng     = r_ng;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random and directed ops against an arithmetic model via a scoreboard
module tb_serial_subtractor;
  localparam int W = 16;
  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] a, b, diff;
  logic         busy, done, borrow, zr, ng;
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  typedef struct {
    logic [W-1:0] diff;
    logic         borrow, zr, ng;
    int           cyc;
  } exp_t;
  exp_t exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .zr(zr), .ng(ng)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain modular subtraction and unsigned compare
  task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   d;
    d        = int'({16'd0, av}) - int'({16'd0, bv});
    e.diff   = W'(d);
    e.borrow = (av < bv);
    e.zr     = (e.diff == '0);
    e.ng     = e.diff[W-1];
    e.cyc    = cyc + W + 1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) chk("spurious_done", done, 1'b0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("diff", diff, e.diff);
        chk("borrow", borrow, e.borrow);
        chk("zr", zr, e.zr);
        chk("ng", ng, e.ng);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle with start low
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int noise_at,
                       input logic [W-1:0] na, input logic [W-1:0] nb);
    int bc;
    bit seen;
    start = 1'b1; a = av; b = bv;
    push_exp(av, bv);
    bc = 0; seen = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        start = 1'b0;
        break;
      end
      bc += int'(busy);
      start = (i == noise_at);
      if (i == noise_at) begin a = na; b = nb; end
      else begin a = W'($urandom); b = W'($urandom); end
    end
    chk("done_seen", seen, 1'b1);
    chk("busy_cycles", bc, W);
    chk("busy_in_done", busy, 1'b0);
  endtask

  initial begin
    int dn;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 1'b0);
    chk("rst_zr", zr, 1'b1);
    chk("rst_ng", ng, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'd5, 16'd3, -1, 0, 0);          @(negedge clk);
    do_op(16'd3, 16'd5, -1, 0, 0);          @(negedge clk);
    do_op(16'h1234, 16'h1234, -1, 0, 0);    @(negedge clk);
    do_op(16'h8000, 16'h0001, -1, 0, 0);    @(negedge clk);
    // ignored start at cycle 5, then back-to-back start in the done cycle
    do_op(16'h0010, 16'h0001, 4, 16'h0000, 16'h0001);
    do_op(16'h0000, 16'h0001, -1, 0, 0);
    @(negedge clk);
    chk("idle_hold_diff", diff, 16'hFFFF);
    chk("idle_hold_borrow", borrow, 1'b1);
    // reset mid-operation aborts without a done pulse
    start = 1'b1; a = 16'd9; b = 16'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_diff", diff, 0);
    chk("abort_zr", zr, 1'b1);
    dn = 0;
    repeat (25) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("abort_no_done", dn, 0);
    do_op(16'd9, 16'd4, -1, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
      do_op(ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 2)) : -1,
            W'($urandom), W'($urandom));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
